rx_frame_fifo: RTL and testbench
================================

RX_FRAME_FIFO -- requirements
Module: rx_frame_fifo

Interface
REQ-001 SHALL have parameter n, default 8, meaning data width of one received character.
REQ-002 SHALL have parameter DEPTH, default 8, meaning FIFO entries; power of 2, at least 2.
REQ-003 SHALL have parameter ERR_W, default 8, meaning width of the parity-error counter.
REQ-004 SHALL have port clk  input  1  single clock, same as receiver clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port Rx_idle  input  1  receiver idle flag; 0 while a frame is in progress.
REQ-007 SHALL have port correct  input  1  receiver parity verdict for the last frame; 1 = good.
REQ-008 SHALL have port out_buffer  input  n  receiver data for the last frame.
REQ-009 SHALL have port rd_en  input  1  consumer pop request.
REQ-010 SHALL have port clr_err  input  1  clears overrun and err_count.
REQ-011 SHALL have port rd_data  output  n  popped character, registered.
REQ-012 SHALL have port rd_valid  output  1  one-cycle strobe qualifying rd_data.
REQ-013 SHALL have port empty  output  1  FIFO holds 0 entries.
REQ-014 SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-016 SHALL have port overrun  output  1  sticky: a good frame was dropped because FIFO was full.
REQ-017 SHALL have port err_count  output  ERR_W  number of frames discarded for parity error, saturating.

Function
REQ-018 SHALL register Rx_idle into rx_idle_q every cycle; frame-done event = Rx_idle & ~rx_idle_q (0->1 transition).
REQ-019 SHALL sample correct and out_buffer in the same cycle Rx_idle is first seen high (event cycle); no extra latency stage.
REQ-020 On event with correct=1 and FIFO not full (or full with accepted pop same cycle), SHALL write out_buffer at wr_ptr and advance wr_ptr.
REQ-021 On event with correct=1 and full with no accepted pop, SHALL drop the character and set overrun=1.
REQ-022 On event with correct=0, SHALL discard the character and increment err_count, holding at 2^ERR_W-1.
REQ-023 Pop accepted when rd_en=1 and empty=0; rd_en while empty SHALL be ignored, no pointer change, rd_valid=0.
REQ-024 Accepted pop SHALL present mem[rd_ptr] on rd_data with rd_valid=1 the following cycle; rd_data holds its value otherwise.
REQ-025 Simultaneous accepted push and pop SHALL leave count unchanged; both pointers advance.
REQ-026 Pointers SHALL wrap modulo DEPTH; count SHALL be 0..DEPTH; full = (count==DEPTH), empty = (count==0), both combinational from count.
REQ-027 Data order SHALL be strict first-in first-out.
REQ-028 clr_err=1 SHALL clear overrun and err_count next cycle; if an overrun or error event coincides, the event wins (flag set / counter = 1).
REQ-029 Rx_idle held low or held high SHALL generate no events; only the rising transition counts.

Reset
REQ-030 rst_n=0 SHALL immediately force: pointers=0, count=0, empty=1, full=0, rd_valid=0, rd_data=0, overrun=0, err_count=0.
REQ-031 rx_idle_q SHALL reset to 1 so a receiver idle at reset release produces no spurious event.
REQ-032 Reset asserted mid-frame or mid-pop SHALL abandon all content; FIFO contents after reset are don't-care and never readable.

Verification
REQ-033 Single frame: Rx_idle 1->0->1 with correct=1, out_buffer=0x55 -> count=1; rd_en one cycle -> next cycle rd_valid=1, rd_data=0x55, empty=1.
REQ-034 Ordering/wrap: push 0x01..0x0C with pops interleaved so pointers wrap -> pops return 0x01..0x0C in order, count never exceeds 8.
REQ-035 Overrun: push 9 good frames (0xA0..0xA8), no reads -> full=1, overrun=1, reads return 0xA0..0xA7; clr_err -> overrun=0.
REQ-036 Parity error: event with correct=0, out_buffer=0x33 -> count unchanged, err_count=1; 300 such events with ERR_W=8 -> err_count=255.
REQ-037 Simultaneous: full FIFO, event (0xEE) and rd_en same cycle -> count stays 8, overrun=0, 0xEE read last; empty FIFO, rd_en alone -> rd_valid=0.
REQ-038 Reset: 3 entries stored, overrun=1, rst_n low mid-cycle -> outputs at reset values without a clock edge; Rx_idle=1 on release -> no push.

Source files
------------

// File: rtl/rx_frame_fifo.sv
// Receive-side character FIFO sitting behind a UART-style receiver.
// A frame is taken when Rx_idle rises: good-parity characters are queued,
// bad-parity characters are dropped and counted, and a good character
// arriving into a full FIFO (with no pop that cycle) sets a sticky overrun.
module rx_frame_fifo #(
  parameter int n     = 8,
  parameter int DEPTH = 8,
  parameter int ERR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     Rx_idle,
  input  logic                     correct,
  input  logic [n-1:0]             out_buffer,
  input  logic                     rd_en,
  input  logic                     clr_err,
  output logic [n-1:0]             rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
  output logic [ERR_W-1:0]         err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic             rx_idle_q;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [n-1:0]     rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overrun_q, overrun_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [n-1:0]     mem_q [DEPTH];

  logic frame_done, pop_ok, push_ok, drop, bad;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign overrun   = overrun_q;
  assign err_count = err_q;

  // Frame-done detection, push/pop arbitration and next-state computation.
  always_comb begin
    frame_done = Rx_idle & ~rx_idle_q;
    pop_ok     = rd_en & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push_ok    = frame_done & correct & (~full | pop_ok);
    drop       = frame_done & correct & full & ~pop_ok;
    bad        = frame_done & ~correct;

    wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (!push_ok && pop_ok) count_d = count_q - CW'(1);

    rd_valid_d = pop_ok;
    rd_data_d  = pop_ok ? mem_q[rd_ptr_q] : rd_data_q;

    // Events take priority over a coincident clear.
    overrun_d = overrun_q;
    if (drop)         overrun_d = 1'b1;
    else if (clr_err) overrun_d = 1'b0;

    err_d = err_q;
    if (bad) begin
      if (clr_err)            err_d = ERR_W'(1);
      else if (err_q != '1)   err_d = err_q + ERR_W'(1);
    end else if (clr_err) begin
      err_d = '0;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_idle_q  <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      err_q      <= '0;
    end else begin
      rx_idle_q  <= Rx_idle;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overrun_q  <= overrun_d;
      err_q      <= err_d;
    end
  end

  // Storage array; contents are unreachable after reset since count is 0.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= out_buffer;
  end

endmodule

// File: tb/tb_rx_frame_fifo.sv
// Directed bench for rx_frame_fifo: a per-cycle vector table for the basic
// push/pop/parity/clear behaviour, then hand-written multi-cycle sequences.
module tb_rx_frame_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       Rx_idle = 1'b1;
  logic       correct = 1'b1;
  logic [7:0] out_buffer = '0;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       overrun;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_errors = 0;

  rx_frame_fifo #(.n(8), .DEPTH(8), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .Rx_idle(Rx_idle), .correct(correct),
    .out_buffer(out_buffer), .rd_en(rd_en), .clr_err(clr_err),
    .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full),
    .count(count), .overrun(overrun), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idle, corr, data, rd, clr;
    int cnt, vld, rdat, ov, err;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic status(input string tag, input int cnt, input int ov, input int err);
    chk({tag, " count"}, int'(count), cnt);
    chk({tag, " empty"}, int'(empty), (cnt == 0) ? 1 : 0);
    chk({tag, " full"}, int'(full), (cnt == 8) ? 1 : 0);
    chk({tag, " overrun"}, int'(overrun), ov);
    chk({tag, " err_count"}, int'(err_count), err);
  endtask

  task automatic push_frame(input logic [7:0] d, input logic c);
    Rx_idle = 1'b0; correct = c; out_buffer = d;
    step();
    Rx_idle = 1'b1;
    step();
    out_buffer = ~d;
    correct = ~c;
  endtask

  task automatic pop_chk(input string tag, input int exp);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk({tag, " rd_valid"}, int'(rd_valid), 1);
    chk({tag, " rd_data"}, int'(rd_data), exp);
  endtask

  task automatic clear();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    //          idle corr data  rd clr  cnt vld rdat  ov err
    vecs[0]  = '{0, 1, 'h55, 0, 0,  0, 0, 'h00, 0, 0};
    vecs[1]  = '{1, 1, 'h55, 0, 0,  1, 0, 'h00, 0, 0};
    vecs[2]  = '{1, 1, 'h00, 1, 0,  0, 1, 'h55, 0, 0};
    vecs[3]  = '{1, 1, 'h00, 1, 0,  0, 0, 'h55, 0, 0};
    vecs[4]  = '{0, 0, 'h33, 0, 0,  0, 0, 'h55, 0, 0};
    vecs[5]  = '{1, 0, 'h33, 0, 0,  0, 0, 'h55, 0, 1};
    vecs[6]  = '{1, 0, 'h33, 0, 0,  0, 0, 'h55, 0, 1};
    vecs[7]  = '{0, 1, 'h12, 0, 0,  0, 0, 'h55, 0, 1};
    vecs[8]  = '{0, 1, 'h12, 0, 0,  0, 0, 'h55, 0, 1};
    vecs[9]  = '{1, 1, 'h12, 0, 0,  1, 0, 'h55, 0, 1};
    vecs[10] = '{1, 1, 'h00, 0, 1,  1, 0, 'h55, 0, 0};
    vecs[11] = '{0, 0, 'h44, 0, 0,  1, 0, 'h55, 0, 0};
    vecs[12] = '{1, 0, 'h44, 0, 1,  1, 0, 'h55, 0, 1};
    vecs[13] = '{1, 1, 'h00, 1, 0,  0, 1, 'h12, 0, 1};
    vecs[14] = '{1, 1, 'h00, 0, 0,  0, 0, 'h12, 0, 1};

    // Reset state, checked both while held and after release.
    #3;
    status("in_reset", 0, 0, 0);
    chk("in_reset rd_valid", int'(rd_valid), 0);
    chk("in_reset rd_data", int'(rd_data), 0);
    #10 rst_n = 1'b1;
    step(); step();
    status("post_reset", 0, 0, 0);
    chk("post_reset rd_valid", int'(rd_valid), 0);

    // Per-cycle vector table.
    for (int i = 0; i < 15; i++) begin
      Rx_idle    = (vecs[i].idle != 0);
      correct    = (vecs[i].corr != 0);
      out_buffer = 8'(vecs[i].data);
      rd_en      = (vecs[i].rd != 0);
      clr_err    = (vecs[i].clr != 0);
      step();
      status($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ov, vecs[i].err);
      chk($sformatf("vec%0d rd_valid", i), int'(rd_valid), vecs[i].vld);
      chk($sformatf("vec%0d rd_data", i), int'(rd_data), vecs[i].rdat);
    end
    Rx_idle = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    clear();
    status("table_end", 0, 0, 0);

    // Ordering with pointer wrap: 6 in, 4 out, 6 in, 8 out.
    cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      push_frame(8'(i), 1'b1);
      cnt++;
      chk("wrap count", int'(count), cnt);
    end
    for (int i = 1; i <= 4; i++) pop_chk("wrap pop_a", i);
    for (int i = 7; i <= 12; i++) begin
      push_frame(8'(i), 1'b1);
      cnt = (i <= 10) ? i - 4 : i - 4;
      chk("wrap count", int'(count), i - 4);
    end
    status("wrap full", 8, 0, 0);
    for (int i = 5; i <= 12; i++) pop_chk("wrap pop_b", i);
    status("wrap drained", 0, 0, 0);

    // Overrun: ninth good frame into a full FIFO is dropped.
    for (int i = 0; i < 8; i++) push_frame(8'(8'hA0 + i), 1'b1);
    status("ovr full", 8, 0, 0);
    push_frame(8'hA8, 1'b1);
    status("ovr dropped", 8, 1, 0);
    for (int i = 0; i < 8; i++) pop_chk("ovr pop", 'hA0 + i);
    status("ovr drained", 0, 1, 0);
    clear();
    status("ovr cleared", 0, 0, 0);

    // Parity errors: counter increments and saturates at 255.
    push_frame(8'h33, 1'b0);
    status("par one", 0, 0, 1);
    for (int i = 1; i < 300; i++) push_frame(8'h33, 1'b0);
    status("par sat", 0, 0, 255);
    clear();
    status("par cleared", 0, 0, 0);

    // Push and pop in the same cycle on a full FIFO.
    for (int i = 0; i < 8; i++) push_frame(8'(8'hB0 + i), 1'b1);
    status("sim full", 8, 0, 0);
    Rx_idle = 1'b0; correct = 1'b1; out_buffer = 8'hEE;
    step();
    Rx_idle = 1'b1; rd_en = 1'b1;
    step();
    rd_en = 1'b0; out_buffer = 8'h00;
    chk("sim rd_valid", int'(rd_valid), 1);
    chk("sim rd_data", int'(rd_data), 'hB0);
    status("sim after", 8, 0, 0);
    for (int i = 1; i < 8; i++) pop_chk("sim pop", 'hB0 + i);
    pop_chk("sim last", 'hEE);
    status("sim drained", 0, 0, 0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("empty pop rd_valid", int'(rd_valid), 0);
    chk("empty pop rd_data hold", int'(rd_data), 'hEE);
    status("empty pop", 0, 0, 0);

    // Asynchronous reset mid-cycle with content, overrun and a live strobe.
    for (int i = 0; i < 9; i++) push_frame(8'(8'hC0 + i), 1'b1);
    for (int i = 0; i < 5; i++) pop_chk("rst pre pop", 'hC0 + i);
    status("rst pre", 3, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    status("rst async", 0, 0, 0);
    chk("rst async rd_valid", int'(rd_valid), 0);
    chk("rst async rd_data", int'(rd_data), 0);
    Rx_idle = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b1;
    step(); step();
    status("rst release", 0, 0, 0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("rst empty pop rd_valid", int'(rd_valid), 0);
    chk("rst empty pop rd_data", int'(rd_data), 0);
    push_frame(8'hD1, 1'b1);
    status("rst reuse", 1, 0, 0);
    pop_chk("rst reuse pop", 'hD1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
